// File: rtl/pixel_array_sequencer.sv
// Pixel array frame sequencer: erase, expose, ramp conversion, then row-by-row
// readout with a valid/ready handshake on the captured row.
module pixel_array_sequencer #(
  parameter int unsigned PIXEL_ARRAY_HEIGHT = 2,
  parameter int unsigned PIXEL_ARRAY_WIDTH  = 2,
  parameter int unsigned PIXEL_BITS         = 8,
  parameter int unsigned ERASE_CYCLES       = 5,
  parameter int unsigned EXPOSE_CYCLES      = 10
) (
  input  logic                                        CLK,
  input  logic                                        RESET,
  input  logic                                        START,
  output logic                                        BUSY,
  output logic                                        ERASE,
  output logic                                        EXPOSE,
  output logic                                        RAMP,
  output logic [7:0]                                  COUNTER,
  output logic [PIXEL_ARRAY_HEIGHT-1:0]               READ,
  input  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0]     PIXEL_DATA,
  output logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0]     OUT_DATA,
  output logic [((PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1)-1:0] OUT_ROW,
  output logic                                        OUT_VALID,
  input  logic                                        OUT_READY,
  output logic                                        FRAME_DONE
);

  localparam int unsigned ROW_W   = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;
  localparam int unsigned DATA_W  = PIXEL_ARRAY_WIDTH * PIXEL_BITS;
  localparam int unsigned MAX_EE  = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES : EXPOSE_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_EE > 256) ? MAX_EE : 256;
  // One extra value of headroom so the terminal count is always representable.
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] ERASE_LAST  = CNT_W'(ERASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] EXPOSE_LAST = CNT_W'(EXPOSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CONV_LAST   = CNT_W'(255);
  localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(PIXEL_ARRAY_HEIGHT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StErase,
    StExpose,
    StConvert,
    StReadRow,
    StOutput,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [DATA_W-1:0]   out_data_q;
  logic [ROW_W-1:0]    out_row_q;

  // State, cycle counter, row index and captured row registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      row_q      <= '0;
      out_data_q <= '0;
      out_row_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      // Row bus is only meaningful while its read select is asserted.
      if (state_q == StReadRow) begin
        out_data_q <= PIXEL_DATA;
        out_row_q  <= row_q;
      end
    end
  end

  // Next-state logic: phase timing via the shared cycle counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        row_d = '0;
        if (START) state_d = StErase;
      end
      StErase: begin
        if (cnt_q == ERASE_LAST) begin
          cnt_d   = '0;
          state_d = StExpose;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StExpose: begin
        if (cnt_q == EXPOSE_LAST) begin
          cnt_d   = '0;
          state_d = StConvert;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StConvert: begin
        if (cnt_q == CONV_LAST) begin
          cnt_d   = '0;
          row_d   = '0;
          state_d = StReadRow;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StReadRow: begin
        state_d = StOutput;
      end
      StOutput: begin
        if (OUT_READY) begin
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            state_d = StDone;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = StReadRow;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        row_d   = '0;
      end
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    BUSY       = (state_q != StIdle);
    ERASE      = (state_q == StErase);
    EXPOSE     = (state_q == StExpose);
    RAMP       = (state_q == StConvert);
    COUNTER    = (state_q == StConvert) ? cnt_q[7:0] : 8'd0;
    OUT_VALID  = (state_q == StOutput);
    FRAME_DONE = (state_q == StDone);
    OUT_DATA   = out_data_q;
    OUT_ROW    = out_row_q;
    READ       = '0;
    for (int i = 0; i < int'(PIXEL_ARRAY_HEIGHT); i++) begin
      READ[i] = (state_q == StReadRow) && (row_q == ROW_W'(i));
    end
  end

endmodule

// File: tb/tb_pixel_array_sequencer.sv
// Directed bench for pixel_array_sequencer with default parameters.
module tb_pixel_array_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic        BUSY, ERASE, EXPOSE, RAMP;
  logic [7:0]  COUNTER;
  logic [1:0]  READ;
  logic [15:0] PIXEL_DATA;
  logic [15:0] OUT_DATA;
  logic [0:0]  OUT_ROW;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        FRAME_DONE;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  pixel_array_sequencer dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .START      (START),
    .BUSY       (BUSY),
    .ERASE      (ERASE),
    .EXPOSE     (EXPOSE),
    .RAMP       (RAMP),
    .COUNTER    (COUNTER),
    .READ       (READ),
    .PIXEL_DATA (PIXEL_DATA),
    .OUT_DATA   (OUT_DATA),
    .OUT_ROW    (OUT_ROW),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .FRAME_DONE (FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  // Array model: each row presents its own pattern while selected.
  always_comb begin
    if (READ[0])      PIXEL_DATA = 16'hA55A;
    else if (READ[1]) PIXEL_DATA = 16'h1234;
    else              PIXEL_DATA = 16'hDEAD;
  end

  typedef struct packed {
    int          cyc;
    logic        busy;
    logic        erase;
    logic        expose;
    logic        ramp;
    logic [7:0]  counter;
    logic [1:0]  read;
    logic        valid;
    logic        done;
    logic        chk;
    logic        row;
    logic [15:0] data;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Advance one rising edge and return at the following falling edge.
  task automatic tick();
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic start_frame();
    START = 1'b1;
    cyc   = 0;
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_busy"},    32'(BUSY),       32'd0);
    check({tag, "_erase"},   32'(ERASE),      32'd0);
    check({tag, "_expose"},  32'(EXPOSE),     32'd0);
    check({tag, "_ramp"},    32'(RAMP),       32'd0);
    check({tag, "_counter"}, 32'(COUNTER),    32'd0);
    check({tag, "_read"},    32'(READ),       32'd0);
    check({tag, "_data"},    32'(OUT_DATA),   32'd0);
    check({tag, "_row"},     32'(OUT_ROW),    32'd0);
    check({tag, "_valid"},   32'(OUT_VALID),  32'd0);
    check({tag, "_done"},    32'(FRAME_DONE), 32'd0);
  endtask

  task automatic run_table(input string tag);
    start_frame();
    for (int i = 0; i < 16; i++) begin
      run_to(vecs[i].cyc);
      check($sformatf("%s_v%0d_busy", tag, i),    32'(BUSY),       32'(vecs[i].busy));
      check($sformatf("%s_v%0d_erase", tag, i),   32'(ERASE),      32'(vecs[i].erase));
      check($sformatf("%s_v%0d_expose", tag, i),  32'(EXPOSE),     32'(vecs[i].expose));
      check($sformatf("%s_v%0d_ramp", tag, i),    32'(RAMP),       32'(vecs[i].ramp));
      check($sformatf("%s_v%0d_counter", tag, i), 32'(COUNTER),    32'(vecs[i].counter));
      check($sformatf("%s_v%0d_read", tag, i),    32'(READ),       32'(vecs[i].read));
      check($sformatf("%s_v%0d_valid", tag, i),   32'(OUT_VALID),  32'(vecs[i].valid));
      check($sformatf("%s_v%0d_done", tag, i),    32'(FRAME_DONE), 32'(vecs[i].done));
      if (vecs[i].chk) begin
        check($sformatf("%s_v%0d_row", tag, i),  32'(OUT_ROW),  32'(vecs[i].row));
        check($sformatf("%s_v%0d_data", tag, i), 32'(OUT_DATA), 32'(vecs[i].data));
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    //          cyc  bsy er ex rp cnt     read   vl dn chk row data
    vecs[0]  = '{0,   0, 0, 0, 0, 8'd0,   2'b00, 0, 0, 0, 0, 16'h0};
    vecs[1]  = '{1,   1, 1, 0, 0, 8'd0,   2'b00, 0, 0, 0, 0, 16'h0};
    vecs[2]  = '{5,   1, 1, 0, 0, 8'd0,   2'b00, 0, 0, 0, 0, 16'h0};
    vecs[3]  = '{6,   1, 0, 1, 0, 8'd0,   2'b00, 0, 0, 0, 0, 16'h0};
    vecs[4]  = '{15,  1, 0, 1, 0, 8'd0,   2'b00, 0, 0, 0, 0, 16'h0};
    vecs[5]  = '{16,  1, 0, 0, 1, 8'd0,   2'b00, 0, 0, 0, 0, 16'h0};
    vecs[6]  = '{17,  1, 0, 0, 1, 8'd1,   2'b00, 0, 0, 0, 0, 16'h0};
    vecs[7]  = '{116, 1, 0, 0, 1, 8'd100, 2'b00, 0, 0, 0, 0, 16'h0};
    vecs[8]  = '{271, 1, 0, 0, 1, 8'd255, 2'b00, 0, 0, 0, 0, 16'h0};
    vecs[9]  = '{272, 1, 0, 0, 0, 8'd0,   2'b01, 0, 0, 0, 0, 16'h0};
    vecs[10] = '{273, 1, 0, 0, 0, 8'd0,   2'b00, 1, 0, 1, 0, 16'hA55A};
    vecs[11] = '{274, 1, 0, 0, 0, 8'd0,   2'b10, 0, 0, 1, 0, 16'hA55A};
    vecs[12] = '{275, 1, 0, 0, 0, 8'd0,   2'b00, 1, 0, 1, 1, 16'h1234};
    vecs[13] = '{276, 1, 0, 0, 0, 8'd0,   2'b00, 0, 1, 1, 1, 16'h1234};
    vecs[14] = '{277, 0, 0, 0, 0, 8'd0,   2'b00, 0, 0, 0, 0, 16'h0};
    vecs[15] = '{279, 0, 0, 0, 0, 8'd0,   2'b00, 0, 0, 0, 0, 16'h0};

    RESET     = 1'b1;
    START     = 1'b0;
    OUT_READY = 1'b1;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    check_idle_reset("por");

    // Nominal frame with the downstream always ready.
    run_table("f1");

    // Back-pressure on row 0: everything holds while OUT_READY is low.
    OUT_READY = 1'b0;
    start_frame();
    run_to(273);
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", 32'(OUT_VALID), 32'd1);
      check("stall_row",   32'(OUT_ROW),   32'd0);
      check("stall_data",  32'(OUT_DATA),  32'hA55A);
      check("stall_read",  32'(READ),      32'd0);
      tick();
    end
    check("stall_end_valid", 32'(OUT_VALID), 32'd1);
    OUT_READY = 1'b1;
    tick();
    check("stall_rel_read",  32'(READ),      32'b10);
    check("stall_rel_valid", 32'(OUT_VALID), 32'd0);
    tick();
    check("stall_r1_valid", 32'(OUT_VALID), 32'd1);
    check("stall_r1_row",   32'(OUT_ROW),   32'd1);
    check("stall_r1_data",  32'(OUT_DATA),  32'h1234);
    tick();
    check("stall_done", 32'(FRAME_DONE), 32'd1);
    tick();
    check("stall_idle", 32'(BUSY), 32'd0);

    // START during EXPOSE and during DONE must not disturb the frame.
    start_frame();
    run_to(10);
    START = 1'b1;
    tick();
    check("ign_expose", 32'(EXPOSE), 32'd1);
    run_to(15);
    check("ign_exp_last", 32'(EXPOSE), 32'd1);
    tick();
    check("ign_ramp",    32'(RAMP),    32'd1);
    check("ign_counter", 32'(COUNTER), 32'd0);
    run_to(276);
    check("ign_done", 32'(FRAME_DONE), 32'd1);
    START = 1'b1;
    tick();
    check("ign_idle0", 32'(BUSY), 32'd0);
    tick();
    check("ign_idle1", 32'(BUSY), 32'd0);
    check("ign_erase", 32'(ERASE), 32'd0);

    // Reset mid-conversion, then a full frame must still time correctly.
    start_frame();
    run_to(116);
    check("mid_counter", 32'(COUNTER), 32'd100);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check_idle_reset("mid");
    run_table("f2");

    // RESET wins over START in IDLE.
    START = 1'b1;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("rs_busy0", 32'(BUSY), 32'd0);
    tick();
    check("rs_busy1",  32'(BUSY),  32'd0);
    check("rs_erase1", 32'(ERASE), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pixel_array_sequencer.md
PIXEL_ARRAY_SEQUENCER -- requirements
Module: pixel_array_sequencer

Interface
REQ-001 SHALL have parameter PIXEL_ARRAY_HEIGHT, default 2, number of pixel rows.
REQ-002 SHALL have parameter PIXEL_ARRAY_WIDTH, default 2, number of pixels per row.
REQ-003 SHALL have parameter PIXEL_BITS, default 8, bits per pixel value.
REQ-004 SHALL have parameter ERASE_CYCLES, default 5, ERASE pulse length in cycles (>=1).
REQ-005 SHALL have parameter EXPOSE_CYCLES, default 10, EXPOSE pulse length in cycles (>=1).
REQ-006 SHALL have one clock and a synchronous, active-high reset.
REQ-007 SHALL have port CLK  input  1  sole clock; all state changes on rising edge.
REQ-008 SHALL have port RESET  input  1  synchronous active-high reset.
REQ-009 SHALL have port START  input  1  frame request, sampled only in IDLE.
REQ-010 SHALL have port BUSY  output  1  high in every state except IDLE.
REQ-011 SHALL have port ERASE  output  1  pixel array erase strobe.
REQ-012 SHALL have port EXPOSE  output  1  pixel array expose strobe.
REQ-013 SHALL have port RAMP  output  1  ADC ramp enable.
REQ-014 SHALL have port COUNTER  output  8  ADC code broadcast to all pixels.
REQ-015 SHALL have port READ  output  PIXEL_ARRAY_HEIGHT  one-hot row read select.
REQ-016 SHALL have port PIXEL_DATA  input  PIXEL_ARRAY_WIDTH*PIXEL_BITS  shared row data bus from array.
REQ-017 SHALL have port OUT_DATA  output  PIXEL_ARRAY_WIDTH*PIXEL_BITS  captured row.
REQ-018 SHALL have port OUT_ROW  output  $clog2(PIXEL_ARRAY_HEIGHT) (min 1)  row index of OUT_DATA.
REQ-019 SHALL have port OUT_VALID  output  1  OUT_DATA/OUT_ROW valid.
REQ-020 SHALL have port OUT_READY  input  1  downstream accepts when high with OUT_VALID.
REQ-021 SHALL have port FRAME_DONE  output  1  single-cycle end-of-frame pulse.

Function
REQ-022 SHALL implement states IDLE, ERASE, EXPOSE, CONVERT, READ_ROW, OUTPUT, DONE.
REQ-023 IDLE: START=1 -> ERASE next cycle; START=0 -> stay; START ignored in all other states.
REQ-024 ERASE: ERASE=1 for exactly ERASE_CYCLES cycles, then EXPOSE.
REQ-025 EXPOSE: EXPOSE=1 for exactly EXPOSE_CYCLES cycles, then CONVERT.
REQ-026 CONVERT: RAMP=1 for exactly 256 cycles, COUNTER=0 on first cycle, +1 each cycle, 255 on last; then READ_ROW with row index 0.
REQ-027 COUNTER SHALL be 0 in every state except CONVERT; no wrap to 0 occurs inside CONVERT.
REQ-028 ERASE, EXPOSE, RAMP SHALL be mutually exclusive and 0 outside their own state.
REQ-029 READ_ROW: one cycle, READ = 1<<row, all other states READ=0; PIXEL_DATA captured into OUT_DATA at end of this cycle, OUT_ROW=row; next state OUTPUT.
REQ-030 OUTPUT: OUT_VALID=1; OUT_DATA/OUT_ROW stable until handshake; OUT_VALID=1 and OUT_READY=1 -> row<last: row+1, READ_ROW; row=last: DONE.
REQ-031 OUT_READY SHALL be ignored outside OUTPUT; OUT_VALID=0 outside OUTPUT.
REQ-032 DONE: FRAME_DONE=1 for one cycle, next IDLE; START in DONE ignored.
REQ-033 Latency START-sample to first OUT_VALID SHALL be ERASE_CYCLES+EXPOSE_CYCLES+258 cycles.
REQ-034 With OUT_READY held 1, each row SHALL take 2 cycles (READ_ROW+OUTPUT).
REQ-035 Internal cycle counter SHALL be wide enough for max(ERASE_CYCLES, EXPOSE_CYCLES, 256).

Reset
REQ-036 RESET=1 at a rising edge SHALL force IDLE, row=0, cycle counter=0 regardless of state, including mid-frame.
REQ-037 Outputs after reset: BUSY=0, ERASE=0, EXPOSE=0, RAMP=0, COUNTER=0, READ=0, OUT_DATA=0, OUT_ROW=0, OUT_VALID=0, FRAME_DONE=0.
REQ-038 RESET SHALL take priority over START and OUT_READY in the same cycle.

Verification
REQ-039 Defaults, START=1 at cycle 0, OUT_READY=1 -> ERASE cycles 1-5, EXPOSE 6-15, RAMP 16-271 with COUNTER 0..255, READ=2'b01 cycle 272, OUT_VALID cycle 273 OUT_ROW=0, READ=2'b10 cycle 274, OUT_VALID 275 OUT_ROW=1, FRAME_DONE 276, BUSY=0 from 277.
REQ-040 PIXEL_DATA=16'hA55A during READ[0], 16'h1234 during READ[1] -> OUT_DATA 16'hA55A (row 0) then 16'h1234 (row 1).
REQ-041 OUT_READY=0 for 10 cycles in OUTPUT row 0 -> OUT_VALID, OUT_DATA, OUT_ROW held stable, READ=0, no progress; advance 1 cycle after OUT_READY=1.
REQ-042 START pulses during EXPOSE and during DONE -> no restart, no timing change; second frame only after START in IDLE.
REQ-043 RESET=1 at COUNTER=100 in CONVERT -> next cycle all outputs at reset values; subsequent START yields full frame timing per REQ-039.
REQ-044 START and RESET both 1 in IDLE -> stays IDLE, BUSY=0.
